window_scan_controller: RTL and testbench

//  Sequences the 3x3 window reader across the whole image in raster order (valid positions only, no padding).
//  For each window it drives start row/col and a held enable, waits for window-ready, then pulses the median filter.

---
 rtl/window_scan_controller_pkg.sv | 26 ++
 rtl/window_scan_controller_if.sv | 52 +++++
 rtl/window_scan_controller_pos_counter.sv | 42 ++++
 rtl/window_scan_controller.sv | 161 ++++++++++++++++
 tb/tb_window_scan_controller.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/window_scan_controller_pkg.sv
// Shared definitions for the window scan controller: FSM state encoding,
// default geometry and the helper that derives the last valid window origin.
package window_scan_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RDY,
    S_FILT,
    S_ADV,
    S_GAP,
    S_DONE
  } scan_state_t;

  localparam int DEF_WINDOW_SIZE = 3;
  localparam int DEF_BUS_WIDTH   = 32;
  localparam int DEF_IMG_WIDTH   = 512;
  localparam int DEF_IMG_HEIGHT  = 512;
  localparam int DEF_TIMEOUT     = 4096;

  // Largest top-left coordinate at which a full window still fits (no padding).
  function automatic int last_origin(input int img_extent, input int win_size);
    return img_extent - win_size;
  endfunction

endpackage

// File: rtl/window_scan_controller_if.sv
// Handshake bundle between the scan controller (master) and the
// top-level control plus reader/filter pair (slave side).
interface window_scan_controller_if
  import window_scan_controller_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH
);

  logic                 Scan_Start;
  logic                 Scan_Abort;
  logic [BUS_WIDTH-1:0] Scan_Rstrt;
  logic [BUS_WIDTH-1:0] Scan_Cstrt;
  logic                 Scan_WinEn;
  logic                 Scan_WinRDY;
  logic                 Scan_FiltStrt;
  logic                 Scan_FiltDone;
  logic [BUS_WIDTH-1:0] Scan_OutAddr;
  logic                 Scan_Busy;
  logic                 Scan_Done;
  logic                 Scan_Err;

  modport master (
    input  Scan_Start,
    input  Scan_Abort,
    input  Scan_WinRDY,
    input  Scan_FiltDone,
    output Scan_Rstrt,
    output Scan_Cstrt,
    output Scan_WinEn,
    output Scan_FiltStrt,
    output Scan_OutAddr,
    output Scan_Busy,
    output Scan_Done,
    output Scan_Err
  );

  modport slave (
    output Scan_Start,
    output Scan_Abort,
    output Scan_WinRDY,
    output Scan_FiltDone,
    input  Scan_Rstrt,
    input  Scan_Cstrt,
    input  Scan_WinEn,
    input  Scan_FiltStrt,
    input  Scan_OutAddr,
    input  Scan_Busy,
    input  Scan_Done,
    input  Scan_Err
  );

endinterface

// File: rtl/window_scan_controller_pos_counter.sv
// Raster-order row/col counter over valid window origins, with a flag
// marking the final (bottom-right) origin.
module window_scan_controller_pos_counter
  import window_scan_controller_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int LAST_ROW  = 0,
  parameter int LAST_COL  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 advance,
  output logic [BUS_WIDTH-1:0] row,
  output logic [BUS_WIDTH-1:0] col,
  output logic                 last
);

  logic row_at_end;
  logic col_at_end;

  assign row_at_end = (row == BUS_WIDTH'(LAST_ROW));
  assign col_at_end = (col == BUS_WIDTH'(LAST_COL));
  assign last       = row_at_end && col_at_end;

  // Column wraps into the next row; the row wraps too so a stray advance
  // after the last origin can never leave the valid range.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_at_end) begin
        col <= '0;
        row <= row_at_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/window_scan_controller.sv
// Walks a WINDOW_SIZE square window over every valid image position in raster
// order, handshaking with the window reader and the median filter per window.
module window_scan_controller
  import window_scan_controller_pkg::*;
#(
  parameter int WINDOW_SIZE = DEF_WINDOW_SIZE,
  parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                      Scan_Clk,
  input  logic                      Scan_Rset,
  window_scan_controller_if.master  scan
);

  localparam int LAST_ROW = last_origin(IMG_HEIGHT, WINDOW_SIZE);
  localparam int LAST_COL = last_origin(IMG_WIDTH, WINDOW_SIZE);
  localparam int HALF     = WINDOW_SIZE / 2;
  localparam int WD_W     = $clog2(TIMEOUT) + 1;

  if (IMG_WIDTH < WINDOW_SIZE || IMG_HEIGHT < WINDOW_SIZE) begin : g_bad_image
    $error("window_scan_controller: image smaller than the scan window");
  end
  if (WINDOW_SIZE < 3 || (WINDOW_SIZE % 2) == 0) begin : g_bad_window
    $error("window_scan_controller: WINDOW_SIZE must be odd and at least 3");
  end

  scan_state_t          state;
  logic [WD_W-1:0]      wd;
  logic                 wd_expired;
  logic [BUS_WIDTH-1:0] row;
  logic [BUS_WIDTH-1:0] col;
  logic                 last_pos;
  logic                 pos_clear;
  logic                 pos_advance;
  logic [BUS_WIDTH-1:0] center_addr;

  assign wd_expired  = (wd == WD_W'(TIMEOUT - 1));
  assign pos_clear   = (state == S_IDLE) && scan.Scan_Start && !scan.Scan_Abort;
  assign pos_advance = (state == S_ADV) && !scan.Scan_Abort;

  // Centre pixel of the window, wrapped to the bus width like the memory address.
  assign center_addr = (row + BUS_WIDTH'(HALF)) * BUS_WIDTH'(IMG_WIDTH)
                     + (col + BUS_WIDTH'(HALF));

  window_scan_controller_pos_counter #(
    .BUS_WIDTH (BUS_WIDTH),
    .LAST_ROW  (LAST_ROW),
    .LAST_COL  (LAST_COL)
  ) u_pos (
    .clk     (Scan_Clk),
    .rst     (Scan_Rset),
    .clear   (pos_clear),
    .advance (pos_advance),
    .row     (row),
    .col     (col),
    .last    (last_pos)
  );

  always_ff @(posedge Scan_Clk) begin
    if (Scan_Rset) begin
      state              <= S_IDLE;
      wd                 <= '0;
      scan.Scan_Rstrt    <= '0;
      scan.Scan_Cstrt    <= '0;
      scan.Scan_OutAddr  <= '0;
      scan.Scan_WinEn    <= 1'b0;
      scan.Scan_FiltStrt <= 1'b0;
      scan.Scan_Busy     <= 1'b0;
      scan.Scan_Done     <= 1'b0;
      scan.Scan_Err      <= 1'b0;
    end else begin
      scan.Scan_FiltStrt <= 1'b0;
      scan.Scan_Done     <= 1'b0;
      // Abort outranks every handshake input and leaves the error flag alone.
      if (state != S_IDLE && scan.Scan_Abort) begin
        state           <= S_IDLE;
        wd              <= '0;
        scan.Scan_WinEn <= 1'b0;
        scan.Scan_Busy  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (scan.Scan_Start && !scan.Scan_Abort) begin
              state           <= S_REQ;
              wd              <= '0;
              scan.Scan_Rstrt <= '0;
              scan.Scan_Cstrt <= '0;
              scan.Scan_Busy  <= 1'b1;
              scan.Scan_Err   <= 1'b0;
            end
          end
          S_REQ: begin
            state             <= S_WAIT_RDY;
            wd                <= '0;
            scan.Scan_Rstrt   <= row;
            scan.Scan_Cstrt   <= col;
            scan.Scan_OutAddr <= center_addr;
            scan.Scan_WinEn   <= 1'b1;
          end
          S_WAIT_RDY: begin
            if (scan.Scan_WinRDY) begin
              state              <= S_FILT;
              wd                 <= '0;
              scan.Scan_FiltStrt <= 1'b1;
            end else if (wd_expired) begin
              state           <= S_IDLE;
              wd              <= '0;
              scan.Scan_WinEn <= 1'b0;
              scan.Scan_Busy  <= 1'b0;
              scan.Scan_Err   <= 1'b1;
            end else begin
              wd <= wd + 1'b1;
            end
          end
          S_FILT: begin
            if (scan.Scan_FiltDone) begin
              state           <= S_ADV;
              wd              <= '0;
              scan.Scan_WinEn <= 1'b0;
            end else if (wd_expired) begin
              state           <= S_IDLE;
              wd              <= '0;
              scan.Scan_WinEn <= 1'b0;
              scan.Scan_Busy  <= 1'b0;
              scan.Scan_Err   <= 1'b1;
            end else begin
              wd <= wd + 1'b1;
            end
          end
          S_ADV: begin
            wd <= '0;
            if (last_pos) begin
              state          <= S_DONE;
              scan.Scan_Done <= 1'b1;
            end else begin
              state <= S_GAP;
            end
          end
          S_GAP: begin
            state <= S_REQ;
            wd    <= '0;
          end
          S_DONE: begin
            state          <= S_IDLE;
            wd             <= '0;
            scan.Scan_Busy <= 1'b0;
          end
          default: begin
            state           <= S_IDLE;
            wd              <= '0;
            scan.Scan_WinEn <= 1'b0;
            scan.Scan_Busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_window_scan_controller.sv
// Self-checking bench for window_scan_controller on a 5x4 image with a 3x3 window:
// cycle-exact vector table, directed corner sequences and randomized scans vs. a window-list model.
module tb_window_scan_controller;

  localparam int W  = 3;
  localparam int IW = 5;
  localparam int IH = 4;
  localparam int TO = 16;
  localparam int BW = 32;

  typedef struct {
    int rst, start, abort, rdy, fdone;
    int winen, fs, busy, done, err;
    int chk_pos, chk_addr;
    int rstrt, cstrt, addr;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [31:0] c;
    logic [31:0] a;
  } win_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  window_scan_controller_if #(.BUS_WIDTH(BW)) bus ();

  window_scan_controller #(
    .WINDOW_SIZE (W),
    .BUS_WIDTH   (BW),
    .IMG_WIDTH   (IW),
    .IMG_HEIGHT  (IH),
    .TIMEOUT     (TO)
  ) dut (
    .Scan_Clk  (clk),
    .Scan_Rset (rst),
    .scan      (bus)
  );

  always #5 clk = ~clk;

  vec_t vecs[15];
  win_t fs_q[$];
  win_t exp_q[$];
  int   done_cnt, shape_viol, low_run;
  bit   seen_high;
  bit   bfm_on = 1'b0, reader_alive, rnd_mode, noise_on, fd_pending;
  int   en_cnt, cur_rdy, fd_cnt, fd_fixed;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock: sample DUT outputs 1 time unit after the edge, then let the
  // reader/filter models choose the inputs for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.Scan_FiltStrt) begin
      fs_q.push_back('{bus.Scan_Rstrt, bus.Scan_Cstrt, bus.Scan_OutAddr});
      if (!bus.Scan_WinEn) shape_viol++;
    end
    if (bus.Scan_Done) done_cnt++;
    if (bus.Scan_WinEn) begin
      if (seen_high && low_run != 0 && low_run < 2) shape_viol++;
      seen_high = 1'b1;
      low_run   = 0;
    end else begin
      low_run++;
    end
    if (bfm_on) begin
      bus.Scan_Start    = 1'b0;
      bus.Scan_FiltDone = 1'b0;
      if (bus.Scan_WinEn) begin
        en_cnt++;
        if (en_cnt == 1 && rnd_mode) cur_rdy = $urandom_range(1, 5);
      end else begin
        en_cnt = 0;
      end
      bus.Scan_WinRDY = reader_alive && bus.Scan_WinEn && (en_cnt >= cur_rdy);
      if (bus.Scan_FiltStrt) begin
        fd_pending = 1'b1;
        fd_cnt     = rnd_mode ? $urandom_range(1, 4) : fd_fixed;
      end
      if (fd_pending) begin
        if (fd_cnt <= 1) begin
          bus.Scan_FiltDone = 1'b1;
          fd_pending        = 1'b0;
        end else begin
          fd_cnt--;
        end
      end
      if (noise_on) begin
        if (bus.Scan_Busy && $urandom_range(0, 3) == 0) bus.Scan_Start = 1'b1;
        if (!fd_pending && !bus.Scan_FiltDone && !bus.Scan_WinRDY && $urandom_range(0, 2) == 0)
          bus.Scan_FiltDone = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    rst               = (v.rst != 0);
    bus.Scan_Start    = (v.start != 0);
    bus.Scan_Abort    = (v.abort != 0);
    bus.Scan_WinRDY   = (v.rdy != 0);
    bus.Scan_FiltDone = (v.fdone != 0);
    tick();
    checkOutput($sformatf("vec%0d_winen", idx), 32'(bus.Scan_WinEn), v.winen);
    checkOutput($sformatf("vec%0d_filtstrt", idx), 32'(bus.Scan_FiltStrt), v.fs);
    checkOutput($sformatf("vec%0d_busy", idx), 32'(bus.Scan_Busy), v.busy);
    checkOutput($sformatf("vec%0d_done", idx), 32'(bus.Scan_Done), v.done);
    checkOutput($sformatf("vec%0d_err", idx), 32'(bus.Scan_Err), v.err);
    if (v.chk_pos != 0) begin
      checkOutput($sformatf("vec%0d_rstrt", idx), bus.Scan_Rstrt, v.rstrt);
      checkOutput($sformatf("vec%0d_cstrt", idx), bus.Scan_Cstrt, v.cstrt);
    end
    if (v.chk_addr != 0)
      checkOutput($sformatf("vec%0d_outaddr", idx), bus.Scan_OutAddr, v.addr);
  endtask

  // Reference: every window origin in raster order with its centre-pixel address.
  task automatic build_expected();
    exp_q.delete();
    for (int r = 0; r <= IH - W; r++)
      for (int c = 0; c <= IW - W; c++)
        exp_q.push_back('{r, c, (r + W / 2) * IW + (c + W / 2)});
  endtask

  task automatic bfm_setup(input int rdy_d, input int fd_d, input bit rnd, input bit noise);
    fs_q.delete();
    done_cnt = 0; shape_viol = 0; low_run = 0; seen_high = 1'b0;
    en_cnt = 0; fd_pending = 1'b0; fd_cnt = 0;
    cur_rdy = rdy_d; fd_fixed = fd_d; rnd_mode = rnd; noise_on = noise;
    reader_alive = 1'b1; bfm_on = 1'b1;
    bus.Scan_Abort = 1'b0; bus.Scan_WinRDY = 1'b0; bus.Scan_FiltDone = 1'b0;
  endtask

  task automatic run_scan(input int rdy_d, input int fd_d, input bit rnd, input bit noise, input string tag);
    int guard;
    bfm_setup(rdy_d, fd_d, rnd, noise);
    bus.Scan_Start = 1'b1;
    tick();
    checkOutput({tag, "_busy_after_start"}, 32'(bus.Scan_Busy), 1);
    guard = 0;
    while (done_cnt == 0 && guard < 2000) begin
      tick();
      guard++;
    end
    tick();
    checkOutput({tag, "_done_count"}, done_cnt, 1);
    checkOutput({tag, "_busy_after_done"}, 32'(bus.Scan_Busy), 0);
    checkOutput({tag, "_err"}, 32'(bus.Scan_Err), 0);
    checkOutput({tag, "_winen_shape"}, shape_viol, 0);
    build_expected();
    checkOutput({tag, "_window_count"}, fs_q.size(), exp_q.size());
    for (int i = 0; i < fs_q.size() && i < exp_q.size(); i++) begin
      checkOutput($sformatf("%s_w%0d_row", tag, i), fs_q[i].r, exp_q[i].r);
      checkOutput($sformatf("%s_w%0d_col", tag, i), fs_q[i].c, exp_q[i].c);
      checkOutput($sformatf("%s_w%0d_addr", tag, i), fs_q[i].a, exp_q[i].a);
    end
    bfm_on = 1'b0;
  endtask

  task automatic reset_mid_scan();
    int guard;
    bfm_setup(3, 2, 1'b0, 1'b0);
    bus.Scan_Start = 1'b1;
    tick();
    guard = 0;
    while (fs_q.size() < 4 && guard < 500) begin
      tick();
      guard++;
    end
    checkOutput("rst_reached_window4", fs_q.size(), 4);
    rst = 1'b1;
    tick();
    checkOutput("rst_winen", 32'(bus.Scan_WinEn), 0);
    checkOutput("rst_filtstrt", 32'(bus.Scan_FiltStrt), 0);
    checkOutput("rst_busy", 32'(bus.Scan_Busy), 0);
    checkOutput("rst_done", 32'(bus.Scan_Done), 0);
    checkOutput("rst_err", 32'(bus.Scan_Err), 0);
    checkOutput("rst_rstrt", bus.Scan_Rstrt, 0);
    checkOutput("rst_cstrt", bus.Scan_Cstrt, 0);
    checkOutput("rst_outaddr", bus.Scan_OutAddr, 0);
    rst = 1'b0;
    run_scan(3, 2, 1'b0, 1'b0, "after_rst");
  endtask

  task automatic timeout_seq();
    int guard;
    bfm_setup(3, 2, 1'b0, 1'b0);
    reader_alive = 1'b0;
    bus.Scan_Start = 1'b1;
    tick();
    guard = 0;
    while (!bus.Scan_WinEn && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("to_winen_rise", 32'(bus.Scan_WinEn), 1);
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k == TO - 1) begin
        checkOutput("to_err_early", 32'(bus.Scan_Err), 0);
        checkOutput("to_winen_held", 32'(bus.Scan_WinEn), 1);
      end
    end
    checkOutput("to_err_set", 32'(bus.Scan_Err), 1);
    checkOutput("to_winen_low", 32'(bus.Scan_WinEn), 0);
    checkOutput("to_busy_low", 32'(bus.Scan_Busy), 0);
    checkOutput("to_no_done", done_cnt, 0);
    tick();
    checkOutput("to_err_sticky", 32'(bus.Scan_Err), 1);
    bus.Scan_Start = 1'b1;
    tick();
    checkOutput("to_err_cleared", 32'(bus.Scan_Err), 0);
    checkOutput("to_restart_busy", 32'(bus.Scan_Busy), 1);
    bus.Scan_Abort = 1'b1;
    tick();
    bus.Scan_Abort = 1'b0;
    checkOutput("to_abort_idle", 32'(bus.Scan_Busy), 0);
    bfm_on = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: actual=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    bus.Scan_Start    = 1'b0;
    bus.Scan_Abort    = 1'b0;
    bus.Scan_WinRDY   = 1'b0;
    bus.Scan_FiltDone = 1'b0;

    // rst start abort rdy fdone | winen fs busy done err | chk_pos chk_addr | rstrt cstrt addr
    vecs[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1,  0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0,  0, 0, 1, 0, 0,  1, 1,  0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 1,  1, 0, 1, 0, 0,  1, 1,  0, 0, 6};
    vecs[3]  = '{0, 1, 0, 0, 0,  1, 0, 1, 0, 0,  1, 1,  0, 0, 6};
    vecs[4]  = '{0, 0, 0, 1, 0,  1, 1, 1, 0, 0,  1, 1,  0, 0, 6};
    vecs[5]  = '{0, 0, 0, 1, 0,  1, 0, 1, 0, 0,  1, 1,  0, 0, 6};
    vecs[6]  = '{0, 0, 0, 0, 1,  0, 0, 1, 0, 0,  1, 1,  0, 0, 6};
    vecs[7]  = '{0, 0, 0, 1, 0,  0, 0, 1, 0, 0,  1, 1,  0, 0, 6};
    vecs[8]  = '{0, 0, 0, 1, 0,  0, 0, 1, 0, 0,  1, 1,  0, 0, 6};
    vecs[9]  = '{0, 0, 0, 0, 0,  1, 0, 1, 0, 0,  1, 1,  0, 1, 7};
    vecs[10] = '{0, 0, 1, 1, 0,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0};
    vecs[12] = '{0, 1, 0, 0, 0,  0, 0, 1, 0, 0,  1, 0,  0, 0, 0};
    vecs[13] = '{0, 0, 0, 0, 0,  1, 0, 1, 0, 0,  1, 1,  0, 0, 6};
    vecs[14] = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1,  0, 0, 0};

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);
    rst = 1'b0;
    bus.Scan_Abort = 1'b0;

    run_scan(3, 2, 1'b0, 1'b0, "full");
    reset_mid_scan();
    timeout_seq();
    for (int s = 0; s < 4; s++) run_scan(0, 0, 1'b1, 1'b1, $sformatf("rand%0d", s));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
